// File: rtl/multi_cycle_controller_if.sv
// -----------------------------------------------------------------------------
// multi_cycle_controller_if
//
// Purpose: bundles every signal between the multi-cycle controller and the
// datapath/memory side (instruction opcode, status flags, control strobes).
//
// Signals:
//   opcode[3:0]    IR[15:12], stable from DECODE until the instruction ends
//   zero           ALU zero flag
//   mem_ready      memory handshake; an access completes in a cycle where it is 1
//   ALUFunc[1:0]   00 ADD, 01 SUB, 10 AND, 11 NOT
//   alu_src_a      0 PC, 1 ACC
//   alu_src_b[1:0] 00 zero, 01 const 1, 10 MDR
//   mem_read, mem_write, i_or_d (0 PC address, 1 IR[11:0])
//   ir_write, pc_write, acc_write
//   pc_src         0 ALU result, 1 {PC[15:12], IR[11:0]}
//   mem_to_acc     0 ALU, 1 MDR
//   halted         high while in HALT
//   state_dbg[2:0] current controller state: 0 FETCH, 1 DECODE, 2 MEM_RD,
//                  3 MEM_WR, 4 ALU_WB, 5 JUMP, 6 BRANCH, 7 HALT
//
// Memory handshake: the controller holds a strobe (mem_read/mem_write) high
// for as long as it waits; the access is complete in the first cycle where
// mem_ready is sampled 1 with the strobe high, and the FSM leaves the memory
// state on that clock edge.
//
// Modports: master = controller (drives control), slave = datapath side.
// -----------------------------------------------------------------------------
interface multi_cycle_controller_if;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [1:0] ALUFunc;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       acc_write;
    logic       pc_src;
    logic       mem_to_acc;
    logic       halted;
    logic [2:0] state_dbg;

    modport master (
        input  opcode, zero, mem_ready,
        output ALUFunc, alu_src_a, alu_src_b, mem_read, mem_write, i_or_d,
               ir_write, pc_write, acc_write, pc_src, mem_to_acc, halted,
               state_dbg
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  ALUFunc, alu_src_a, alu_src_b, mem_read, mem_write, i_or_d,
               ir_write, pc_write, acc_write, pc_src, mem_to_acc, halted,
               state_dbg
    );
endinterface

// File: rtl/multi_cycle_controller.sv
// -----------------------------------------------------------------------------
// multi_cycle_controller
//
// Purpose: Moore-style control FSM for a 16-bit accumulator machine
// (LDA, STA, ADD, SUB, AND, NOT, JMP, JZ, HALT; other opcodes are NOP).
//
// Ports:
//   clk  single clock, rising edge
//   rst  synchronous active-high reset; all outputs are forced to 0 while high
//   bus  multi_cycle_controller_if.master (opcode/zero/mem_ready in, control
//        strobes and state_dbg out)
//
// Build option: define MEM_WAIT_EN to honour mem_ready in FETCH/MEM_RD/MEM_WR.
// Without it mem_ready is ignored (treated as 1) and each memory state lasts
// exactly one cycle.
//
// Outputs are decoded combinationally from the state register, plus mem_ready
// in FETCH and zero in BRANCH, because those strobes must react in the same
// cycle the flag is presented.
// -----------------------------------------------------------------------------
module multi_cycle_controller (
    input  logic                       clk,
    input  logic                       rst,
    multi_cycle_controller_if.master   bus
);
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_MEM_WR = 3'd3,
        ST_ALU_WB = 3'd4,
        ST_JUMP   = 3'd5,
        ST_BRANCH = 3'd6,
        ST_HALT   = 3'd7
    } state_t;

    localparam logic [3:0] OP_LDA  = 4'b0000;
    localparam logic [3:0] OP_STA  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_NOT  = 4'b0101;
    localparam logic [3:0] OP_JMP  = 4'b0110;
    localparam logic [3:0] OP_JZ   = 4'b0111;
    localparam logic [3:0] OP_HALT = 4'b1111;

    state_t state_q, state_d;
    logic   ready;

`ifdef MEM_WAIT_EN
    assign ready = bus.mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
    assign ready = 1'b1;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  if (ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (bus.opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_AND: state_d = ST_MEM_RD;
                    OP_STA:  state_d = ST_MEM_WR;
                    OP_NOT:  state_d = ST_ALU_WB;
                    OP_JMP:  state_d = ST_JUMP;
                    OP_JZ:   state_d = ST_BRANCH;
                    OP_HALT: state_d = ST_HALT;
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEM_RD: if (ready) state_d = ST_ALU_WB;
            ST_MEM_WR: if (ready) state_d = ST_FETCH;
            ST_ALU_WB: state_d = ST_FETCH;
            ST_JUMP:   state_d = ST_FETCH;
            ST_BRANCH: state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_FETCH;
        else     state_q <= state_d;
    end

    // Output decode; everything is 0 while rst is high.
    logic [1:0] alu_func;
    logic       src_a;
    logic [1:0] src_b;
    logic       mem_rd, mem_wr, iord, irw, pcw, accw, pcs, m2a, hlt;

    always_comb begin
        alu_func = 2'b00;
        src_a    = 1'b0;
        src_b    = 2'b00;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        iord     = 1'b0;
        irw      = 1'b0;
        pcw      = 1'b0;
        accw     = 1'b0;
        pcs      = 1'b0;
        m2a      = 1'b0;
        hlt      = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    // PC + 1 through the ALU; IR and PC only load on the
                    // cycle the fetch completes, never during a wait.
                    mem_rd = 1'b1;
                    src_b  = 2'b01;
                    irw    = ready;
                    pcw    = ready;
                end
                ST_MEM_RD: begin
                    mem_rd = 1'b1;
                    iord   = 1'b1;
                end
                ST_MEM_WR: begin
                    mem_wr = 1'b1;
                    iord   = 1'b1;
                end
                ST_ALU_WB: begin
                    src_a = 1'b1;
                    src_b = 2'b10;
                    accw  = 1'b1;
                    m2a   = (bus.opcode == OP_LDA);
                    case (bus.opcode)
                        OP_SUB:  alu_func = 2'b01;
                        OP_AND:  alu_func = 2'b10;
                        OP_NOT:  alu_func = 2'b11;
                        default: alu_func = 2'b00;
                    endcase
                end
                ST_JUMP: begin
                    pcw = 1'b1;
                    pcs = 1'b1;
                end
                ST_BRANCH: begin
                    // ALU passes ACC so zero reflects the accumulator.
                    src_a = 1'b1;
                    pcs   = 1'b1;
                    pcw   = bus.zero;
                end
                ST_HALT:  hlt = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.ALUFunc    = alu_func;
    assign bus.alu_src_a  = src_a;
    assign bus.alu_src_b  = src_b;
    assign bus.mem_read   = mem_rd;
    assign bus.mem_write  = mem_wr;
    assign bus.i_or_d     = iord;
    assign bus.ir_write   = irw;
    assign bus.pc_write   = pcw;
    assign bus.acc_write  = accw;
    assign bus.pc_src     = pcs;
    assign bus.mem_to_acc = m2a;
    assign bus.halted     = hlt;
    assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_multi_cycle_controller.sv
module tb_multi_cycle_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;

    multi_cycle_controller_if bus();

    multi_cycle_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    // Step codes, matching the state_dbg encoding of the interface.
    localparam logic [2:0] S_F  = 3'd0;
    localparam logic [2:0] S_D  = 3'd1;
    localparam logic [2:0] S_MR = 3'd2;
    localparam logic [2:0] S_MW = 3'd3;
    localparam logic [2:0] S_AW = 3'd4;
    localparam logic [2:0] S_J  = 3'd5;
    localparam logic [2:0] S_B  = 3'd6;
    localparam logic [2:0] S_H  = 3'd7;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    logic [13:0] act_v;
    assign act_v = {bus.ALUFunc, bus.alu_src_a, bus.alu_src_b, bus.mem_read,
                    bus.mem_write, bus.i_or_d, bus.ir_write, bus.pc_write,
                    bus.acc_write, bus.pc_src, bus.mem_to_acc, bus.halted};

    // Sequence of steps an instruction walks through, fetch first.
    function automatic void path_of(input logic [3:0] op, output logic [3:0][2:0] p, output int len);
        case (op)
            4'h0, 4'h2, 4'h3, 4'h4: begin p = {S_AW, S_MR, S_D, S_F}; len = 4; end
            4'h1: begin p = {S_F, S_MW, S_D, S_F}; len = 3; end
            4'h5: begin p = {S_F, S_AW, S_D, S_F}; len = 3; end
            4'h6: begin p = {S_F, S_J,  S_D, S_F}; len = 3; end
            4'h7: begin p = {S_F, S_B,  S_D, S_F}; len = 3; end
            4'hF: begin p = {S_F, S_H,  S_D, S_F}; len = 3; end
            default: begin p = {S_F, S_F, S_D, S_F}; len = 2; end
        endcase
    endfunction

    // Control word each step must present.
    function automatic logic [13:0] exp_vec(input logic [2:0] st, input logic [3:0] op,
                                            input logic z, input logic rdy, input logic r);
        logic [1:0] alu; logic sa; logic [1:0] sb;
        logic mr, mw, iod, irw, pcw, accw, pcs, m2a, h;
        alu = 2'b00; sa = 1'b0; sb = 2'b00; mr = 1'b0; mw = 1'b0; iod = 1'b0;
        irw = 1'b0; pcw = 1'b0; accw = 1'b0; pcs = 1'b0; m2a = 1'b0; h = 1'b0;
        if (!r) begin
            if (st == S_F)  begin mr = 1'b1; sb = 2'b01; irw = rdy; pcw = rdy; end
            if (st == S_MR) begin mr = 1'b1; iod = 1'b1; end
            if (st == S_MW) begin mw = 1'b1; iod = 1'b1; end
            if (st == S_AW) begin
                sa = 1'b1; sb = 2'b10; accw = 1'b1; m2a = (op == 4'h0);
                alu = (op == 4'h3) ? 2'b01 : (op == 4'h4) ? 2'b10 : (op == 4'h5) ? 2'b11 : 2'b00;
            end
            if (st == S_J)  begin pcw = 1'b1; pcs = 1'b1; end
            if (st == S_B)  begin sa = 1'b1; pcs = 1'b1; pcw = z; end
            if (st == S_H)  h = 1'b1;
        end
        return {alu, sa, sb, mr, mw, iod, irw, pcw, accw, pcs, m2a, h};
    endfunction

    // Reference model: position within the current instruction's path.
    int m_idx   = 0;
    bit m_valid = 1'b0;

    always @(negedge clk) begin
        logic [3:0][2:0] p;
        int len;
        logic [2:0] st;
        logic rdy;
        rdy = WAIT_EN ? bus.mem_ready : 1'b1;
        path_of(bus.opcode, p, len);
        st = p[m_idx[1:0]];
        check("outputs", 32'(act_v), 32'(exp_vec(st, bus.opcode, bus.zero, rdy, rst)));
        if (m_valid) check("state", 32'(bus.state_dbg), 32'(st));
        if (rst) begin
            m_idx   = 0;
            m_valid = 1'b1;
        end else if ((st == S_F || st == S_MR || st == S_MW) && !rdy) begin
            m_idx = m_idx;
        end else if (st != S_H) begin
            m_idx = (m_idx + 1 == len) ? 0 : m_idx + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic measure(input logic [3:0] op, output int cyc);
        bus.opcode = op;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (bus.state_dbg != S_F && cyc < 20);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int cnt;
        logic [3:0] lat_op [9];
        int lat_exp [9];
        logic [2:0] seq31 [4];
        lat_op  = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA};
        lat_exp = '{4, 3, 4, 4, 4, 3, 3, 3, 2};
        seq31   = '{S_F, S_D, S_MR, S_AW};

        bus.opcode = 4'h2; bus.zero = 1'b0; bus.mem_ready = 1'b1; rst = 1'b1;

        // Reset: outputs all zero and state FETCH after the first edge.
        tick();
        check("reset_outputs", 32'(act_v), 32'd0);
        check("reset_state", 32'(bus.state_dbg), 32'(S_F));
        tick(); tick();
        rst = 1'b0;
        settle();
        check("first_fetch_state", 32'(bus.state_dbg), 32'(S_F));
        check("first_fetch_read", 32'(bus.mem_read), 32'd1);

        // ADD walks FETCH, DECODE, MEM_RD, ALU_WB; acc_write only in cycle 4.
        for (int c = 0; c < 4; c++) begin
            check("add_state", 32'(bus.state_dbg), 32'(seq31[c]));
            check("add_acc_write", 32'(bus.acc_write), (c == 3) ? 32'd1 : 32'd0);
            if (c == 3) check("add_alufunc", 32'(bus.ALUFunc), 32'd0);
            tick();
        end
        check("add_back_fetch", 32'(bus.state_dbg), 32'(S_F));

        // Zero-wait latencies.
        for (int i = 0; i < 9; i++) begin
            measure(lat_op[i], lat);
            check($sformatf("latency_op%0h", lat_op[i]), 32'(lat), 32'(lat_exp[i]));
        end

        // JZ taken, then not taken.
        bus.opcode = 4'h7; bus.zero = 1'b1;
        tick(); tick();
        check("jz_taken", 32'({bus.pc_write, bus.pc_src}), 32'b11);
        tick();
        check("jz_taken_fetch", 32'(bus.state_dbg), 32'(S_F));
        bus.zero = 1'b0;
        tick(); tick();
        check("jz_not_taken", 32'({bus.pc_write, bus.pc_src}), 32'b01);
        tick();
        check("jz_not_taken_fetch", 32'(bus.state_dbg), 32'(S_F));

        // HALT holds for 10 cycles, released by a reset pulse.
        bus.opcode = 4'hF;
        tick(); tick();
        for (int i = 0; i < 10; i++) begin
            check("halt_hold", 32'({bus.halted, bus.ir_write, bus.pc_write, bus.acc_write,
                                   bus.mem_write, bus.mem_read}), 32'b100000);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("halt_release_state", 32'(bus.state_dbg), 32'(S_F));
        check("halt_release_halted", 32'(bus.halted), 32'd0);

        // NOP, then reset in the middle of a store.
        bus.opcode = 4'hA;
        check("nop_fetch_writes", 32'({bus.acc_write, bus.mem_write}), 32'd0);
        tick();
        check("nop_decode", 32'(bus.state_dbg), 32'(S_D));
        tick();
        check("nop_fetch_again", 32'(bus.state_dbg), 32'(S_F));
        bus.opcode = 4'h1;
        tick();
        bus.mem_ready = 1'b0;
        tick();
        settle();
        check("sta_mem_write", 32'(bus.mem_write), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        settle();
        check("sta_abort_write", 32'(bus.mem_write), 32'd0);
        check("sta_abort_state", 32'(bus.state_dbg), 32'(S_F));

`ifdef MEM_WAIT_EN
        // Store stretched by three wait cycles.
        bus.opcode = 4'h1;
        tick(); tick();
        bus.mem_ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            if (bus.mem_write) cnt++;
            tick();
        end
        bus.mem_ready = 1'b1;
        settle();
        if (bus.mem_write) cnt++;
        tick();
        check("sta_wait_write_cycles", 32'(cnt), 32'd4);
        check("sta_wait_fetch", 32'(bus.state_dbg), 32'(S_F));

        // Fetch stretched by two wait cycles.
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("fetch_wait_we", 32'({bus.ir_write, bus.pc_write}), 32'b00);
            check("fetch_wait_state", 32'(bus.state_dbg), 32'(S_F));
            tick();
        end
        bus.mem_ready = 1'b1;
        settle();
        check("fetch_done_we", 32'({bus.ir_write, bus.pc_write}), 32'b11);
        tick();
        check("fetch_done_decode", 32'(bus.state_dbg), 32'(S_D));
`else
        // mem_ready is ignored: a store still takes three cycles.
        bus.mem_ready = 1'b0;
        measure(4'h1, lat);
        check("sta_no_wait_latency", 32'(lat), 32'd3);
        cnt = 0;
`endif

        // Randomized traffic against the model.
        repeat (3000) begin
            tick();
            rst = ($urandom_range(0, 99) < ((bus.opcode == 4'hF && m_idx == 2) ? 30 : 2));
            if (m_idx == 0) bus.opcode = 4'($urandom_range(0, 15));
            bus.zero      = 1'($urandom_range(0, 1));
            bus.mem_ready = ($urandom_range(0, 9) < 7);
        end
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
